// File: rtl/ahb_uart_satellite.sv
// AHB-Lite slave for an 8N1 UART: TX holding register + shifter, RX synchronizer + shifter,
// four word registers (TXDATA, RXDATA, STATUS, BAUD); TX writes wait-state while the holding register is full.
module ahb_uart_satellite #(
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic        uart_tx,
  input  logic        uart_rx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  logic        dp_valid_r, dp_write_r;
  logic [1:0]  dp_idx_r;
  logic [15:0] baud_r;
  logic        accept_s, stall_s, tx_wr_s, baud_wr_s, rd_rx_s, rd_stat_s;

  logic        tx_full_r;
  logic [7:0]  tx_hold_r, tx_shift_r;
  logic [15:0] tx_cnt_r, tx_div_r;
  logic [2:0]  tx_bits_r;
  uart_state_t tx_state_r, tx_state_nx_s;
  logic        tx_tick_s, tx_load_s, tx_busy_s;

  logic        rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic [7:0]  rx_shift_r, rx_byte_r;
  logic [15:0] rx_cnt_r, rx_div_r;
  logic [2:0]  rx_bits_r;
  uart_state_t rx_state_r, rx_state_nx_s;
  logic        rx_valid_r, overrun_r, frame_err_r;
  logic        rx_fall_s, rx_half_s, rx_tick_s, rx_ok_s, rx_bad_s;

  logic        unused_s;

  assign unused_s = ^{hsize, hburst, haddr[31:4], haddr[1:0], htrans[0], hwdata[31:16]};

  assign accept_s  = hsel & hready & htrans[1];
  // A TXDATA write holds the bus until the holding register has been drained by the TX FSM.
  assign stall_s   = dp_valid_r & dp_write_r & (dp_idx_r == REG_TXDATA) & tx_full_r;
  assign tx_wr_s   = dp_valid_r & dp_write_r & (dp_idx_r == REG_TXDATA) & ~tx_full_r;
  assign baud_wr_s = dp_valid_r & dp_write_r & (dp_idx_r == REG_BAUD);
  assign rd_rx_s   = dp_valid_r & ~dp_write_r & (dp_idx_r == REG_RXDATA);
  assign rd_stat_s = dp_valid_r & ~dp_write_r & (dp_idx_r == REG_STATUS);
  assign hreadyout = ~stall_s;
  assign hresp     = 1'b0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_idx_r   <= 2'd0;
    end else if (hready) begin
      dp_valid_r <= accept_s;
      dp_write_r <= hwrite;
      dp_idx_r   <= haddr[3:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      baud_r <= DEFAULT_DIV;
    end else if (baud_wr_s) begin
      baud_r <= (hwdata[15:0] < 16'd4) ? 16'd4 : hwdata[15:0];
    end
  end

  always_comb begin
    hrdata = 32'd0;
    if (dp_valid_r && !dp_write_r) begin
      case (dp_idx_r)
        REG_TXDATA: hrdata = 32'd0;
        REG_RXDATA: hrdata = {24'd0, rx_byte_r};
        REG_STATUS: hrdata = {27'd0, frame_err_r, overrun_r, rx_valid_r, tx_full_r, tx_busy_s};
        REG_BAUD:   hrdata = {16'd0, baud_r};
        default:    hrdata = 32'd0;
      endcase
    end else begin
      hrdata = 32'd0;
    end
  end

  assign tx_tick_s = (tx_cnt_r == tx_div_r - 16'd1);

  always_ff @(posedge clk) begin
    if (!nrst) tx_state_r <= ST_IDLE;
    else       tx_state_r <= tx_state_nx_s;
  end

  always_comb begin
    tx_state_nx_s = tx_state_r;
    tx_load_s     = 1'b0;
    case (tx_state_r)
      ST_IDLE: begin
        if (tx_full_r) begin
          tx_state_nx_s = ST_START;
          tx_load_s     = 1'b1;
        end else begin
          tx_state_nx_s = ST_IDLE;
        end
      end
      ST_START: tx_state_nx_s = tx_tick_s ? ST_DATA : ST_START;
      ST_DATA:  tx_state_nx_s = (tx_tick_s && tx_bits_r == 3'd7) ? ST_STOP : ST_DATA;
      ST_STOP: begin
        if (tx_tick_s && tx_full_r) begin
          tx_state_nx_s = ST_START;
          tx_load_s     = 1'b1;
        end else if (tx_tick_s) begin
          tx_state_nx_s = ST_IDLE;
        end else begin
          tx_state_nx_s = ST_STOP;
        end
      end
      default: tx_state_nx_s = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (tx_state_r)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = tx_shift_r[0];
      default:  uart_tx = 1'b1;
    endcase
    tx_busy_s = (tx_state_r != ST_IDLE);
  end

  // The divisor is captured at each frame start so BAUD writes never disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tx_full_r  <= 1'b0;
      tx_hold_r  <= 8'd0;
      tx_shift_r <= 8'd0;
      tx_cnt_r   <= 16'd0;
      tx_bits_r  <= 3'd0;
      tx_div_r   <= DEFAULT_DIV;
    end else begin
      if (tx_wr_s) begin
        tx_full_r <= 1'b1;
        tx_hold_r <= hwdata[7:0];
      end else if (tx_load_s) begin
        tx_full_r <= 1'b0;
      end
      if (tx_load_s) begin
        tx_shift_r <= tx_hold_r;
        tx_div_r   <= baud_r;
        tx_cnt_r   <= 16'd0;
        tx_bits_r  <= 3'd0;
      end else if (tx_state_r != ST_IDLE) begin
        if (tx_tick_s) begin
          tx_cnt_r <= 16'd0;
          if (tx_state_r == ST_DATA) begin
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_bits_r  <= tx_bits_r + 3'd1;
          end
        end else begin
          tx_cnt_r <= tx_cnt_r + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= uart_rx;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  assign rx_fall_s = rx_prev_r & ~rx_sync2_r;
  assign rx_half_s = (rx_cnt_r == {1'b0, rx_div_r[15:1]} - 16'd1);
  assign rx_tick_s = (rx_cnt_r == rx_div_r - 16'd1);
  assign rx_ok_s   = (rx_state_r == ST_STOP) & rx_tick_s & rx_sync2_r;
  assign rx_bad_s  = (rx_state_r == ST_STOP) & rx_tick_s & ~rx_sync2_r;

  always_ff @(posedge clk) begin
    if (!nrst) rx_state_r <= ST_IDLE;
    else       rx_state_r <= rx_state_nx_s;
  end

  always_comb begin
    rx_state_nx_s = rx_state_r;
    case (rx_state_r)
      ST_IDLE:  rx_state_nx_s = rx_fall_s ? ST_START : ST_IDLE;
      ST_START: begin
        if (rx_half_s) rx_state_nx_s = rx_sync2_r ? ST_IDLE : ST_DATA;
        else           rx_state_nx_s = ST_START;
      end
      ST_DATA:  rx_state_nx_s = (rx_tick_s && rx_bits_r == 3'd7) ? ST_STOP : ST_DATA;
      ST_STOP:  rx_state_nx_s = rx_tick_s ? ST_IDLE : ST_STOP;
      default:  rx_state_nx_s = ST_IDLE;
    endcase
  end

  // Completion events take priority over the read-side clears.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_cnt_r    <= 16'd0;
      rx_div_r    <= DEFAULT_DIV;
      rx_bits_r   <= 3'd0;
      rx_shift_r  <= 8'd0;
      rx_byte_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      case (rx_state_r)
        ST_IDLE: begin
          rx_cnt_r  <= 16'd0;
          rx_bits_r <= 3'd0;
          rx_div_r  <= baud_r;
        end
        ST_START: rx_cnt_r <= rx_half_s ? 16'd0 : rx_cnt_r + 16'd1;
        ST_DATA: begin
          if (rx_tick_s) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
            rx_bits_r  <= rx_bits_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        ST_STOP: rx_cnt_r <= rx_tick_s ? 16'd0 : rx_cnt_r + 16'd1;
        default: rx_cnt_r <= 16'd0;
      endcase
      if (rx_ok_s) rx_byte_r <= rx_shift_r;
      if (rx_ok_s)      rx_valid_r <= 1'b1;
      else if (rd_rx_s) rx_valid_r <= 1'b0;
      if (rx_ok_s && rx_valid_r) overrun_r <= 1'b1;
      else if (rd_stat_s)        overrun_r <= 1'b0;
      if (rx_bad_s)       frame_err_r <= 1'b1;
      else if (rd_stat_s) frame_err_r <= 1'b0;
    end
  end

endmodule

// File: doc/ahb_uart_satellite.md
# ahb_uart_satellite

AHB-Lite satellite implementing the UART peripheral at 0x2002_0000–0x2002_000F, directly downstream of the AHB-Lite bus multiplexor (UART select). It decodes bus transfers into four 32-bit registers. It drives an 8N1 transmitter with a one-byte holding register and an 8N1 receiver with a one-byte data register. Write wait states are inserted when the transmit path is full.

## Interface
- DEFAULT_DIV, 434, reset value of BAUD divisor (clocks per bit; 50 MHz / 115200)
- clk  in  1  system clock
- nrst  in  1  reset, synchronous, active-low
- hsel  in  1  satellite select from multiplexor
- haddr  in  32  address; bits [3:2] select register
- htrans  in  2  transfer type; transfer valid when htrans[1]=1 (NONSEQ/SEQ)
- hwrite  in  1  1 = write
- hsize  in  3  ignored; all accesses treated as word
- hburst  in  3  ignored
- hwdata  in  32  write data (data phase)
- hready  in  1  bus ready from multiplexor
- hrdata  out  32  read data (data phase)
- hreadyout  out  1  satellite ready
- hresp  out  1  always 0 (OKAY)
- uart_tx  out  1  serial output, idle high
- uart_rx  in  1  serial input, asynchronous

## Operation
- Address phase accepted when hsel && hready && htrans[1]. Latch hwrite and haddr[3:2]; data phase is the next cycle. Otherwise no data phase is pending.
- Register map:
  - 0x0 TXDATA: write loads hwdata[7:0] into holding register and sets tx_full. Read returns 0.
  - 0x4 RXDATA: read returns {24'b0, rx_byte} and clears rx_valid. If rx_valid=0, returns {24'b0, last rx_byte}. Writes ignored.
  - 0x8 STATUS (read): bit0 tx_busy (TX FSM ≠ IDLE), bit1 tx_full, bit2 rx_valid, bit3 overrun, bit4 frame_err, others 0. A read clears bits 3–4. Writes ignored.
  - 0xC BAUD: [15:0] divisor, upper bits read 0. Written values <4 are stored as 4.
- TX write with tx_full=1: hreadyout=0 until the holding register empties. The write completes (hreadyout=1, holding loaded) in the first cycle tx_full is clear. hwdata is held stable by the master.
- TX FSM (IDLE, START, DATA, STOP), bit timer counts divisor clocks:
  - IDLE with tx_full: move holding register to shift register, clear tx_full, enter START.
  - START drives 0. DATA drives bits LSB-first, 8 bits. STOP drives 1.
  - End of STOP: go to START if tx_full, else IDLE.
- RX: 2-flop synchronizer feeds FSM (IDLE, START, DATA, STOP).
  - IDLE: a falling edge enters START. After divisor/2 clocks, sample; if high, treat as glitch and return to IDLE.
  - DATA: sample each following bit every divisor clocks, 8 bits LSB-first.
  - STOP: sample the stop bit. High: store byte and set rx_valid; set overrun first if rx_valid was already 1 (new byte overwrites). Low: discard byte, set frame_err. Return to IDLE.
- Divisor changes take effect at the next frame start.

## Timing
- Reset values: hrdata=0, hreadyout=1, hresp=0, uart_tx=1, both FSMs IDLE, tx_full=0, rx_valid=0, overrun=0, frame_err=0, rx_byte=0, BAUD=DEFAULT_DIV.
- Reads: zero wait states; hrdata is combinational from latched register index during the data phase.
- TXDATA write, data phase cycle T (holding empty, FSM IDLE):
  - tx_full=1 at T+1.
  - START at T+2 with uart_tx=0.
  - Each bit lasts exactly divisor cycles; a frame is 10×divisor cycles.
  - Back-to-back frames have no idle gap.
- rx_valid is set in the cycle after the stop-bit sample.
- Simultaneous events:
  - RXDATA read in the same cycle a byte completes: set wins (rx_valid stays 1, new byte readable).
  - STATUS read in the same cycle overrun or frame_err sets: set wins.
- nrst low mid-frame: on the next edge, abort TX/RX, uart_tx=1, drop pending wait state (hreadyout=1), all state returns to reset values.

## Test plan
- Reset, then read 0x8 → 0x0; read 0xC → 434; uart_tx=1; hreadyout=1.
- Write BAUD=16, write TXDATA=0xA5 → uart_tx low at T+2. Bits over 160 cycles: 0,1,0,1,0,0,1,0,1,1. STATUS bit0=1 during frame.
- BAUD=16, three back-to-back TXDATA writes (0x01, 0x02, 0x03):
  - third write stalls with hreadyout=0 until second byte moves to shift register;
  - 30×16 cycles of contiguous frames.
- Drive 0x3C on uart_rx at 16 clocks/bit → STATUS=0x4, RXDATA=0x3C, then STATUS=0x0.
- Drive two frames without reading → STATUS=0xC, RXDATA=second byte. Drive a frame with stop bit 0 → STATUS bit4=1, rx_valid unchanged. A 3-cycle low glitch → no effect.
- Assert nrst mid-TX frame → uart_tx=1 next cycle, STATUS=0x0, BAUD=434.
